hazard_match_pipe: RTL and testbench

- Supplies the match and status inputs that the pipeline hazard unit evaluates, and obeys its StallD/FlushE outputs.
- Carries register addresses and control bits through the Execute, Memory and Writeback pipeline registers.
- Computes the five address-match signals, BranchTakenE, and the stage write-enable and MemtoReg bits.
- Counts stall and flush cycles for performance monitoring.

---
 rtl/hazard_match_pipe.sv | 127 ++++++++++++
 tb/tb_hazard_match_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_match_pipe.sv
// Execute/Memory/Writeback pipeline registers feeding the hazard unit: address matches,
// stage enables and saturating stall/flush counters. Optional build macro HAZ_MATCH_QUAL_EN.
module hazard_match_pipe #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  RA1D,
  input  logic [RA_W-1:0]  RA2D,
  input  logic [RA_W-1:0]  WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             CondExE,
  input  logic             StallD,
  input  logic             FlushE,
  output logic             Match1E_M,
  output logic             Match1E_W,
  output logic             Match2E_M,
  output logic             Match2E_W,
  output logic             Match12D_E,
  output logic             BranchTakenE,
  output logic             MemtoRegE,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic             MemWriteM,
  output logic [RA_W-1:0]  WA3W,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  logic [RA_W-1:0] RA1E, RA2E, WA3E, WA3M;
  logic            RegWriteE, MemWriteE, BranchE;
  logic            MemtoRegM, MemtoRegW;

  // Execute register: a flush bubbles the stage, a stall freezes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RA1E      <= '0;
      RA2E      <= '0;
      WA3E      <= '0;
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      MemWriteE <= 1'b0;
      BranchE   <= 1'b0;
    end else if (FlushE) begin
      RA1E      <= '0;
      RA2E      <= '0;
      WA3E      <= '0;
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
      MemWriteE <= 1'b0;
      BranchE   <= 1'b0;
    end else if (!StallD) begin
      RA1E      <= RA1D;
      RA2E      <= RA2D;
      WA3E      <= WA3D;
      RegWriteE <= RegWriteD;
      MemtoRegE <= MemtoRegD;
      MemWriteE <= MemWriteD;
      BranchE   <= BranchD;
    end
  end

  // Memory and Writeback registers; a failed condition kills the writes here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      WA3M      <= '0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      WA3W      <= '0;
    end else begin
      RegWriteM <= RegWriteE & CondExE;
      MemWriteM <= MemWriteE & CondExE;
      MemtoRegM <= MemtoRegE;
      WA3M      <= WA3E;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      WA3W      <= WA3M;
    end
  end

  // The load-select in Writeback belongs to the result mux outside this block.
  logic unusedMemtoRegW;
  assign unusedMemtoRegW = MemtoRegW;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallD && (StallCnt != {CNT_W{1'b1}})) StallCnt <= StallCnt + CNT_W'(1);
      if (FlushE && (FlushCnt != {CNT_W{1'b1}})) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

  logic eq1M, eq1W, eq2M, eq2W, eq12E;
  assign eq1M  = (RA1E == WA3M);
  assign eq1W  = (RA1E == WA3W);
  assign eq2M  = (RA2E == WA3M);
  assign eq2W  = (RA2E == WA3W);
  assign eq12E = (RA1D == WA3E) | (RA2D == WA3E);

`ifdef HAZ_MATCH_QUAL_EN
  // Writes to the PC never forward through the register file path.
  localparam logic [RA_W-1:0] PcAddr = {RA_W{1'b1}};
  assign Match1E_M  = eq1M  & RegWriteM & (WA3M != PcAddr);
  assign Match1E_W  = eq1W  & RegWriteW & (WA3W != PcAddr);
  assign Match2E_M  = eq2M  & RegWriteM & (WA3M != PcAddr);
  assign Match2E_W  = eq2W  & RegWriteW & (WA3W != PcAddr);
  assign Match12D_E = eq12E & RegWriteE & (WA3E != PcAddr);
`else
  assign Match1E_M  = eq1M;
  assign Match1E_W  = eq1W;
  assign Match2E_M  = eq2M;
  assign Match2E_W  = eq2W;
  assign Match12D_E = eq12E;
`endif

  assign BranchTakenE = BranchE & CondExE;

endmodule

// File: tb/tb_hazard_match_pipe.sv
// Directed and random-stream bench for hazard_match_pipe with a writeback scoreboard.
module tb_hazard_match_pipe;
  localparam int RA_W  = 4;
  localparam int CNT_W = 16;
  localparam int N     = 40;
`ifdef HAZ_MATCH_QUAL_EN
  localparam bit QUAL = 1'b1;
`else
  localparam bit QUAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [RA_W-1:0] RA1D, RA2D, WA3D;
  logic RegWriteD, MemtoRegD, MemWriteD, BranchD, CondExE, StallD, FlushE;
  logic Match1E_M, Match1E_W, Match2E_M, Match2E_W, Match12D_E;
  logic BranchTakenE, MemtoRegE, RegWriteM, RegWriteW, MemWriteM;
  logic [RA_W-1:0] WA3W;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  int total = 0;
  int bad = 0;
  logic [RA_W:0] exp_q[$];
  logic [RA_W:0] expW;

  logic [RA_W-1:0] hRa1[N], hRa2[N], hWa[N];
  logic hRw[N], hMr[N], hMw[N], hBr[N], hC[N];

  hazard_match_pipe #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD), .BranchD(BranchD),
    .CondExE(CondExE), .StallD(StallD), .FlushE(FlushE),
    .Match1E_M(Match1E_M), .Match1E_W(Match1E_W), .Match2E_M(Match2E_M), .Match2E_W(Match2E_W),
    .Match12D_E(Match12D_E), .BranchTakenE(BranchTakenE), .MemtoRegE(MemtoRegE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemWriteM(MemWriteM), .WA3W(WA3W),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic driveD(input logic [RA_W-1:0] ra1, input logic [RA_W-1:0] ra2,
                        input logic [RA_W-1:0] wa3, input logic rw, input logic mr,
                        input logic mw, input logic br);
    RA1D = ra1; RA2D = ra2; WA3D = wa3;
    RegWriteD = rw; MemtoRegD = mr; MemWriteD = mw; BranchD = br;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic qual(input logic eq, input logic we, input logic [RA_W-1:0] wa);
    return QUAL ? (eq & we & (wa != {RA_W{1'b1}})) : eq;
  endfunction

  initial begin
    driveD('0, '0, '0, 0, 0, 0, 0);
    CondExE = 1'b0; StallD = 1'b0; FlushE = 1'b0;

    // Reset state, then one idle cycle
    repeat (2) tick();
    reset = 1'b1;
    #1;
    check("rst_match", {Match1E_M, Match1E_W, Match2E_M, Match2E_W, Match12D_E}, QUAL ? 5'b00000 : 5'b11111);
    check("rst_we", {RegWriteM, RegWriteW, MemWriteM}, 3'b000);
    check("rst_cnt", {StallCnt, FlushCnt}, 32'h0);
    tick();
    check("idle_match", {Match1E_M, Match1E_W, Match2E_M, Match2E_W, Match12D_E}, QUAL ? 5'b00000 : 5'b11111);
    check("idle_we", {RegWriteM, RegWriteW, MemWriteM, MemtoRegE}, 4'b0000);
    check("idle_cnt", {StallCnt, FlushCnt}, 32'h0);

    // Producer to r3 then consumer of r3
    driveD(0, 0, 3, 1, 0, 0, 0); CondExE = 1'b1;
    tick();
    driveD(3, 0, 0, 0, 0, 0, 0);
    #1 check("fwd_m12", Match12D_E, 1'b1);
    tick();
    check("fwd_m1m", Match1E_M, 1'b1);
    check("fwd_rwm", RegWriteM, 1'b1);
    StallD = 1'b1; driveD(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("fwd_m1w", Match1E_W, 1'b1);
    check("fwd_m1m_gone", Match1E_M, 1'b0);
    check("fwd_rww", RegWriteW, 1'b1);
    check("fwd_wa3w", WA3W, 4'd3);
    StallD = 1'b0;

    // Condition fails while Execute holds a write to r5
    driveD(5, 0, 5, 1, 1, 0, 1); CondExE = 1'b1;
    tick();
    driveD(0, 0, 0, 0, 0, 0, 0);
    #1 check("cond_memtoreg_e", MemtoRegE, 1'b1);
    check("cond_br_taken", BranchTakenE, 1'b1);
    CondExE = 1'b0;
    #1 check("cond_br_not_taken", BranchTakenE, 1'b0);
    StallD = 1'b1;
    tick();
    check("cond_rwm_killed", RegWriteM, 1'b0);
    check("cond_m1m_raw", Match1E_M, QUAL ? 1'b0 : 1'b1);
    StallD = 1'b0;

    // Asynchronous reset with a write in Memory
    driveD(0, 0, 2, 1, 0, 0, 0); CondExE = 1'b1;
    tick();
    driveD(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("arst_rwm_before", RegWriteM, 1'b1);
    reset = 1'b0;
    #1 check("arst_rwm", RegWriteM, 1'b0);
    check("arst_cnt", StallCnt, 16'h0);
    check("arst_wa3w", WA3W, 4'd0);
    tick(); tick();
    reset = 1'b1;

    // Stall and flush together for three cycles
    StallD = 1'b1; FlushE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      driveD(RA_W'($urandom_range(1, 14)), RA_W'($urandom_range(1, 14)), 9, 1, 1, 1, 1);
      tick();
    end
    StallD = 1'b0; FlushE = 1'b0; CondExE = 1'b1;
    driveD(9, 9, 0, 0, 0, 0, 0);
    #1 check("flush_stallcnt", StallCnt, 16'd3);
    check("flush_flushcnt", FlushCnt, 16'd3);
    check("flush_memtoreg_e", MemtoRegE, 1'b0);
    check("flush_br_taken", BranchTakenE, 1'b0);
    check("flush_wa3e", Match12D_E, 1'b0);
    check("flush_m1m", Match1E_M, QUAL ? 1'b0 : 1'b1);

    // Stall alone holds Execute while WA3D=7 waits
    driveD(0, 0, 4, 1, 0, 0, 0);
    tick();
    StallD = 1'b1;
    driveD(4, 4, 7, 1, 0, 0, 0);
    tick();
    check("stall_hold1", Match12D_E, 1'b1);
    tick();
    check("stall_hold2", Match12D_E, 1'b1);
    driveD(7, 7, 7, 1, 0, 0, 0);
    #1 check("stall_not_loaded", Match12D_E, 1'b0);
    StallD = 1'b0;
    tick();
    check("stall_loaded", Match12D_E, 1'b1);
    check("stall_cnt", StallCnt, 16'd5);
    check("stall_flushcnt", FlushCnt, 16'd3);
    driveD(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    check("stall_wa3w", WA3W, 4'd7);
    check("stall_rww", RegWriteW, 1'b1);

    // Random instruction stream with a writeback scoreboard
    for (int k = 0; k < N; k++) begin
      hRa1[k] = RA_W'($urandom_range(0, 3));
      hRa2[k] = RA_W'($urandom_range(0, 3));
      hWa[k]  = ($urandom_range(0, 7) == 0) ? 4'hF : RA_W'($urandom_range(0, 3));
      hRw[k]  = 1'($urandom_range(0, 1));
      hMr[k]  = 1'($urandom_range(0, 1));
      hMw[k]  = 1'($urandom_range(0, 1));
      hBr[k]  = 1'($urandom_range(0, 1));
      hC[k]   = ($urandom_range(0, 3) != 0);
      driveD(hRa1[k], hRa2[k], hWa[k], hRw[k], hMr[k], hMw[k], hBr[k]);
      CondExE = hC[k];
      #1;
      if (k >= 1) begin
        check("rnd_m12", Match12D_E,
              qual((hRa1[k] == hWa[k-1]) | (hRa2[k] == hWa[k-1]), hRw[k-1], hWa[k-1]));
        check("rnd_br", BranchTakenE, hBr[k-1] & hC[k]);
        check("rnd_memtoreg_e", MemtoRegE, hMr[k-1]);
        exp_q.push_back({hRw[k-1] & hC[k], hWa[k-1]});
      end
      if (k >= 2) begin
        check("rnd_m1m", Match1E_M, qual(hRa1[k-1] == hWa[k-2], hRw[k-2] & hC[k-1], hWa[k-2]));
        check("rnd_m2m", Match2E_M, qual(hRa2[k-1] == hWa[k-2], hRw[k-2] & hC[k-1], hWa[k-2]));
        check("rnd_mwm", MemWriteM, hMw[k-2] & hC[k-1]);
      end
      if (k >= 3) begin
        check("rnd_m1w", Match1E_W, qual(hRa1[k-1] == hWa[k-3], hRw[k-3] & hC[k-2], hWa[k-3]));
        check("rnd_m2w", Match2E_W, qual(hRa2[k-1] == hWa[k-3], hRw[k-3] & hC[k-2], hWa[k-3]));
        if (exp_q.size() == 0) begin
          check("rnd_sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          expW = exp_q.pop_front();
          check("rnd_wb", {RegWriteW, WA3W}, expW);
        end
      end
      tick();
    end

    // Stall counter saturation
    driveD(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    StallD = 1'b1;
    repeat (65534) tick();
    check("sat_below", StallCnt, 16'hFFFE);
    tick();
    check("sat_reach", StallCnt, 16'hFFFF);
    repeat (3) tick();
    check("sat_hold", StallCnt, 16'hFFFF);
    check("sat_flushcnt", FlushCnt, 16'h0);
    StallD = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
